// File: rtl/hyperram_responder.sv
// hyperram_responder
//   Memory-side end of a HyperRAM bus, used as a loopback target for
//   hyperram_controller. Decodes the 6-byte command/address phase, applies a
//   fixed initial latency for memory space and register reads, and serves
//   linear bursts from an internal 16-bit word array or the ID0/CR0 registers.
// Ports
//   hram_clk        clock, one DQ byte per cycle while dram_cs_l is low
//   rstn            asynchronous active-low reset
//   dram_cs_l       chip select (active low); high ends/aborts a transaction
//   dram_rst_l      device reset (active low), sampled on hram_clk
//   dram_dq_in      DQ byte from the controller
//   dram_dq_out     DQ byte to the controller (read data)
//   dram_dq_oe_l    DQ output enable (active low)
//   dram_rwds_in    write byte mask (1 = byte not written)
//   dram_rwds_out   latency flag during CA, read strobe during read data
//   dram_rwds_oe_l  RWDS output enable (active low)
//   txn_done        one-cycle pulse when a transaction with full CA ends
//   busy            high while the bus state machine is not idle
module hyperram_responder #(
  parameter int          DEPTH_WORDS   = 1024,
  parameter int          LATENCY_EDGES = 21,
  parameter logic [15:0] ID0_VAL       = 16'h0C81,
  parameter logic [15:0] CR0_RST       = 16'h8F1F
) (
  input  logic       hram_clk,
  input  logic       rstn,
  input  logic       dram_cs_l,
  input  logic       dram_rst_l,
  input  logic [7:0] dram_dq_in,
  output logic [7:0] dram_dq_out,
  output logic       dram_dq_oe_l,
  input  logic       dram_rwds_in,
  output logic       dram_rwds_out,
  output logic       dram_rwds_oe_l,
  output logic       txn_done,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = $clog2(LATENCY_EDGES + 1);

  typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_REGWR, S_WR, S_RD} state_t;

  state_t        r_state, w_state_next;
  logic [39:0]   r_ca;        // first five CA bytes, oldest in the MSBs
  logic [2:0]    r_ca_cnt;    // CA bytes already captured
  logic [LW-1:0] r_lat_cnt;
  logic          r_is_read, r_is_reg, r_reg_hi, r_reg_done;
  logic          r_phase;     // parity of the next data byte (0 = high byte)
  logic [AW-1:0] r_addr;
  logic [15:0]   r_cr0;
  logic [15:0]   r_mem [DEPTH_WORDS];
  logic [7:0]    r_dq_out;
  logic          r_dq_oe_l, r_rwds_out, r_rwds_oe_l, r_txn_done;

  logic [47:0] w_ca;
  logic [31:0] w_waddr;
  logic        w_ca_last, w_lat_last, w_emit, w_advance, w_mem_we;
  logic [15:0] w_rd_word;
  logic [7:0]  w_rd_byte;
  logic [7:0]  w_dq_out_next;
  logic        w_dq_oe_l_next, w_rwds_out_next, w_rwds_oe_l_next, w_txn_done_next;
  logic        w_unused_ca;

  // Full CA word as it stands on the cycle the sixth byte is sampled.
  assign w_ca        = {r_ca, dram_dq_in};
  assign w_waddr     = {w_ca[44:16], w_ca[2:0]};
  // Burst type and reserved CA bits carry no meaning here.
  assign w_unused_ca = ^{w_ca[45], w_ca[15:3], w_waddr};

  assign w_ca_last  = !dram_cs_l && (r_state == S_CA) && (r_ca_cnt == 3'd5);
  assign w_lat_last = (r_state == S_LAT) && (r_lat_cnt == LW'(LATENCY_EDGES - 1));
  // The first read byte is loaded on the last latency edge so it sits on the
  // pins during the first data cycle.
  assign w_emit     = !dram_cs_l && ((w_lat_last && r_is_read) || (r_state == S_RD));
  assign w_advance  = w_emit || (!dram_cs_l && (r_state == S_WR));
  assign w_mem_we   = dram_rst_l && !dram_cs_l && !dram_rwds_in && (r_state == S_WR);
  assign w_rd_word  = r_is_reg ? (r_reg_hi ? r_cr0 : ID0_VAL) : r_mem[r_addr];
  assign w_rd_byte  = r_phase ? w_rd_word[7:0] : w_rd_word[15:8];

  // State register
  always_ff @(posedge hram_clk or negedge rstn) begin
    if (!rstn)           r_state <= S_IDLE;
    else if (!dram_rst_l) r_state <= S_IDLE;
    else                 r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (dram_cs_l) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_next = S_CA;
        S_CA:    if (r_ca_cnt == 3'd5)
                   w_state_next = (!w_ca[47] && w_ca[46]) ? S_REGWR : S_LAT;
        S_LAT:   if (w_lat_last) w_state_next = r_is_read ? S_RD : S_WR;
        default: w_state_next = r_state;
      endcase
    end
  end

  // Output logic (next values of the registered pins)
  always_comb begin
    w_dq_out_next    = 8'h00;
    w_dq_oe_l_next   = 1'b1;
    w_rwds_out_next  = 1'b0;
    w_rwds_oe_l_next = 1'b1;
    w_txn_done_next  = 1'b0;
    if (dram_cs_l) begin
      w_txn_done_next = (r_state == S_LAT) || (r_state == S_REGWR) ||
                        (r_state == S_WR)  || (r_state == S_RD);
    end else begin
      // Signal fixed 2x latency for the rest of the CA phase.
      if ((r_state == S_IDLE) || ((r_state == S_CA) && (r_ca_cnt != 3'd5))) begin
        w_rwds_oe_l_next = 1'b0;
        w_rwds_out_next  = 1'b1;
      end
      if (w_emit) begin
        w_dq_out_next    = w_rd_byte;
        w_dq_oe_l_next   = 1'b0;
        w_rwds_oe_l_next = 1'b0;
        w_rwds_out_next  = !r_phase;
      end
    end
  end

  // Pins and transaction context
  always_ff @(posedge hram_clk or negedge rstn) begin
    if (!rstn) begin
      r_dq_out <= 8'h00; r_dq_oe_l <= 1'b1; r_rwds_out <= 1'b0; r_rwds_oe_l <= 1'b1;
      r_txn_done <= 1'b0; r_ca <= '0; r_ca_cnt <= 3'd0; r_lat_cnt <= '0;
      r_is_read <= 1'b0; r_is_reg <= 1'b0; r_reg_hi <= 1'b0; r_reg_done <= 1'b0;
      r_phase <= 1'b0; r_addr <= '0; r_cr0 <= CR0_RST;
    end else if (!dram_rst_l) begin
      r_dq_out <= 8'h00; r_dq_oe_l <= 1'b1; r_rwds_out <= 1'b0; r_rwds_oe_l <= 1'b1;
      r_txn_done <= 1'b0; r_ca <= '0; r_ca_cnt <= 3'd0; r_lat_cnt <= '0;
      r_is_read <= 1'b0; r_is_reg <= 1'b0; r_reg_hi <= 1'b0; r_reg_done <= 1'b0;
      r_phase <= 1'b0; r_addr <= '0; r_cr0 <= CR0_RST;
    end else begin
      r_dq_out    <= w_dq_out_next;
      r_dq_oe_l   <= w_dq_oe_l_next;
      r_rwds_out  <= w_rwds_out_next;
      r_rwds_oe_l <= w_rwds_oe_l_next;
      r_txn_done  <= w_txn_done_next;
      if (!dram_cs_l && ((r_state == S_IDLE) || (r_state == S_CA))) begin
        r_ca     <= {r_ca[31:0], dram_dq_in};
        r_ca_cnt <= (r_state == S_IDLE) ? 3'd1 : r_ca_cnt + 3'd1;
      end
      if (w_ca_last) begin
        r_is_read  <= w_ca[47];
        r_is_reg   <= w_ca[46];
        r_reg_hi   <= w_waddr[11];
        r_addr     <= w_waddr[AW-1:0];
        r_phase    <= 1'b0;
        r_reg_done <= 1'b0;
        r_lat_cnt  <= '0;
      end
      if (!dram_cs_l && (r_state == S_LAT)) r_lat_cnt <= r_lat_cnt + LW'(1);
      // Address steps after the low byte; power-of-2 depth wraps for free.
      if (w_advance) begin
        r_phase <= !r_phase;
        if (r_phase) r_addr <= r_addr + AW'(1);
      end
      // Only the first two register-write bytes reach CR0; mask is ignored.
      if (!dram_cs_l && (r_state == S_REGWR) && !r_reg_done) begin
        if (!r_phase) r_cr0[15:8] <= dram_dq_in;
        else begin
          r_cr0[7:0] <= dram_dq_in;
          r_reg_done <= 1'b1;
        end
        r_phase <= !r_phase;
      end
    end
  end

  // Word array: contents survive every reset.
  always_ff @(posedge hram_clk) begin
    if (w_mem_we) begin
      if (r_phase) r_mem[r_addr][7:0]  <= dram_dq_in;
      else         r_mem[r_addr][15:8] <= dram_dq_in;
    end
  end

  assign dram_dq_out    = r_dq_out;
  assign dram_dq_oe_l   = r_dq_oe_l;
  assign dram_rwds_out  = r_rwds_out;
  assign dram_rwds_oe_l = r_rwds_oe_l;
  assign txn_done       = r_txn_done;
  assign busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_hyperram_responder.sv
// tb_hyperram_responder
//   Drives HyperRAM transactions into hyperram_responder; a behavioural memory
//   and register model predicts read bytes (pushed to a queue) and a monitor
//   compares every byte the responder drives while chip select is low.
module tb_hyperram_responder;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 21;
  localparam logic [15:0] ID0   = 16'h0C81;
  localparam logic [15:0] CR0R  = 16'h8F1F;

  logic       hram_clk = 1'b0;
  logic       rstn = 1'b0, dram_cs_l = 1'b1, dram_rst_l = 1'b1, dram_rwds_in = 1'b0;
  logic [7:0] dram_dq_in = 8'h00;
  logic [7:0] dram_dq_out;
  logic       dram_dq_oe_l, dram_rwds_out, dram_rwds_oe_l, txn_done, busy;

  hyperram_responder #(
    .DEPTH_WORDS(DEPTH), .LATENCY_EDGES(LAT), .ID0_VAL(ID0), .CR0_RST(CR0R)
  ) dut (
    .hram_clk(hram_clk), .rstn(rstn), .dram_cs_l(dram_cs_l), .dram_rst_l(dram_rst_l),
    .dram_dq_in(dram_dq_in), .dram_dq_out(dram_dq_out), .dram_dq_oe_l(dram_dq_oe_l),
    .dram_rwds_in(dram_rwds_in), .dram_rwds_out(dram_rwds_out),
    .dram_rwds_oe_l(dram_rwds_oe_l), .txn_done(txn_done), .busy(busy)
  );

  always #5 hram_clk = ~hram_clk;

  int unsigned cyc = 0;
  always @(posedge hram_clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] dq; logic rwds; int unsigned cyc; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] model_mem [DEPTH];
  logic [15:0] model_cr0 = CR0R;
  logic [7:0]  wbuf [2*DEPTH];
  logic        mbuf [2*DEPTH];
  int          vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
  task automatic drive(input logic cs_l, input logic [7:0] dq, input logic rwds);
    @(posedge hram_clk); #1;
    dram_cs_l = cs_l; dram_dq_in = dq; dram_rwds_in = rwds;
  endtask

  function automatic logic [15:0] rd_word(input bit rsp, input logic [31:0] a, input int k);
    int idx;
    if (rsp) return a[11] ? model_cr0 : ID0;
    idx = (int'(a % 32'(DEPTH)) + k / 2) % DEPTH;
    return model_mem[idx];
  endfunction

  // One transaction. stop_at: cycle (0 = first CA byte) at which cs_l rises
  // (or rstn falls when stop_rst), -1 to run to completion.
  task automatic txn(input bit rd, input bit rsp, input logic [31:0] a, input int n,
                     input int stop_at, input bit stop_rst);
    logic [47:0] ca;
    logic [15:0] w;
    int ds, tot, nd, idx;
    int unsigned t0;
    exp_t e;
    ca  = {rd, rsp, 1'($urandom), a[31:3], 13'($urandom), a[2:0]};
    ds  = (rsp && !rd) ? 6 : 6 + LAT;
    tot = ds + n;
    nd  = (stop_at < 0) ? n : ((stop_at - ds) > n ? n : (stop_at - ds));
    if (nd < 0) nd = 0;
    t0  = 0;
    for (int j = 0; j < tot; j++) begin
      if (stop_at >= 0 && j == stop_at) break;
      if (j < 6)       drive(1'b0, ca[47-8*j -: 8], 1'b0);
      else if (j < ds) drive(1'b0, 8'($urandom), 1'($urandom));
      else if (rd)     drive(1'b0, 8'($urandom), 1'b0);
      else             drive(1'b0, wbuf[j-ds], mbuf[j-ds]);
      if (j == 0) begin
        t0 = cyc;
        if (rd) for (int k = 0; k < nd; k++) begin
          w = rd_word(rsp, a, k);
          e.dq = (k % 2 == 0) ? w[15:8] : w[7:0];
          e.rwds = (k % 2 == 0);
          e.cyc = t0 + 32'(ds + k);
          exp_q.push_back(e);
        end
      end
      if (j == 2) begin
        @(negedge hram_clk);
        chk("ca_rwds_latency", {62'd0, dram_rwds_oe_l, dram_rwds_out}, 64'd1);
      end
    end
    if (!rd) for (int k = 0; k < nd; k++) begin
      if (rsp) begin
        if (k == 0) model_cr0[15:8] = wbuf[0];
        if (k == 1) model_cr0[7:0]  = wbuf[1];
      end else if (!mbuf[k]) begin
        idx = (int'(a % 32'(DEPTH)) + k / 2) % DEPTH;
        if (k % 2 == 0) model_mem[idx][15:8] = wbuf[k];
        else            model_mem[idx][7:0]  = wbuf[k];
      end
    end
    if (stop_rst) begin
      @(posedge hram_clk); #1;
      rstn = 1'b0; dram_cs_l = 1'b1;
      #1;
      chk("async_reset_pins", {50'd0, dram_dq_out, dram_dq_oe_l, dram_rwds_out,
          dram_rwds_oe_l, busy, txn_done}, {50'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
      model_cr0 = CR0R;
      @(posedge hram_clk); #1;
      rstn = 1'b1;
    end else begin
      drive(1'b1, 8'h00, 1'b0);
      drive(1'b1, 8'h00, 1'b0);
      @(negedge hram_clk);
      chk("txn_end_state", {60'd0, busy, dram_dq_oe_l, dram_rwds_oe_l, txn_done},
          {60'd0, 1'b0, 1'b1, 1'b1, (stop_at < 0 || stop_at >= 6)});
    end
    chk("read_bytes_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Monitor: every byte driven while cs_l is low must be the next expected one.
  initial forever begin
    exp_t e;
    @(negedge hram_clk);
    if (rstn && !dram_cs_l && !dram_dq_oe_l) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_read_byte", {24'd0, cyc, dram_dq_out}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("read_byte", {22'd0, cyc, dram_dq_out, dram_rwds_out, dram_rwds_oe_l},
            {22'd0, e.cyc, e.dq, e.rwds, 1'b0});
      end
    end
  end

  initial begin
    bit          rd, rsp;
    logic [31:0] a;
    int          n, ds, stop;

    repeat (3) @(posedge hram_clk);
    #1;
    chk("reset_pins", {58'd0, dram_dq_oe_l, dram_rwds_out, dram_rwds_oe_l, busy, txn_done,
        |dram_dq_out}, {58'd0, 6'b101000});
    rstn = 1'b1;
    repeat (2) drive(1'b1, 8'h00, 1'b0);

    // Give every word a known value with one long burst.
    for (int k = 0; k < 2*DEPTH; k++) begin wbuf[k] = 8'($urandom); mbuf[k] = 1'b0; end
    txn(1'b0, 1'b0, 32'h0, 2*DEPTH, -1, 1'b0);
    txn(1'b1, 1'b0, 32'h0, 16, -1, 1'b0);

    // Basic write / read-back at word 4.
    wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'hBE; wbuf[3] = 8'hEF;
    txn(1'b0, 1'b0, 32'h4, 4, -1, 1'b0);
    txn(1'b1, 1'b0, 32'h4, 4, -1, 1'b0);

    // Byte masking.
    wbuf[0] = 8'h11; wbuf[1] = 8'h11; wbuf[2] = 8'h22; wbuf[3] = 8'h22;
    txn(1'b0, 1'b0, 32'h10, 4, -1, 1'b0);
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wbuf[2] = 8'hCC; wbuf[3] = 8'hDD;
    mbuf[0] = 1'b0;  mbuf[1] = 1'b1;  mbuf[2] = 1'b1;  mbuf[3] = 1'b0;
    txn(1'b0, 1'b0, 32'h10, 4, -1, 1'b0);
    for (int k = 0; k < 16; k++) mbuf[k] = 1'b0;
    txn(1'b1, 1'b0, 32'h10, 4, -1, 1'b0);

    // Wrap from the top word to word 0.
    for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom);
    txn(1'b0, 1'b0, 32'(DEPTH-1), 8, -1, 1'b0);
    txn(1'b1, 1'b0, 32'(DEPTH-1), 8, -1, 1'b0);
    txn(1'b1, 1'b0, 32'h0, 6, -1, 1'b0);

    // Register space: CR0 write/read, ID0 read, device reset restores CR0.
    wbuf[0] = 8'h8F; wbuf[1] = 8'h17; wbuf[2] = 8'h55;
    txn(1'b0, 1'b1, 32'h800, 3, -1, 1'b0);
    txn(1'b1, 1'b1, 32'h800, 4, -1, 1'b0);
    txn(1'b1, 1'b1, 32'h0, 2, -1, 1'b0);
    @(posedge hram_clk); #1; dram_rst_l = 1'b0;
    @(posedge hram_clk); #1; dram_rst_l = 1'b1;
    model_cr0 = CR0R;
    txn(1'b1, 1'b1, 32'h800, 2, -1, 1'b0);

    // Abort during CA, then a normal read; abort a write after 3 data bytes.
    txn(1'b1, 1'b0, 32'h4, 4, 3, 1'b0);
    txn(1'b1, 1'b0, 32'h4, 4, -1, 1'b0);
    for (int k = 0; k < 6; k++) wbuf[k] = 8'($urandom);
    txn(1'b0, 1'b0, 32'h30, 6, 6 + LAT + 3, 1'b0);
    txn(1'b1, 1'b0, 32'h30, 6, -1, 1'b0);

    // Asynchronous reset in the middle of a read burst.
    wbuf[0] = 8'h12; wbuf[1] = 8'h34;
    txn(1'b0, 1'b1, 32'h800, 2, -1, 1'b0);
    txn(1'b1, 1'b0, 32'h20, 8, 6 + LAT + 3, 1'b1);
    txn(1'b1, 1'b1, 32'h800, 2, -1, 1'b0);
    txn(1'b1, 1'b0, 32'h20, 8, -1, 1'b0);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      rd   = 1'($urandom_range(0, 1));
      rsp  = ($urandom_range(0, 4) == 0);
      a    = $urandom;
      n    = $urandom_range(1, 12);
      ds   = (rsp && !rd) ? 6 : 6 + LAT;
      stop = -1;
      for (int k = 0; k < n; k++) begin
        wbuf[k] = 8'($urandom);
        mbuf[k] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 7) == 0) stop = $urandom_range(1, ds + n - 1);
      txn(rd, rsp, a, n, stop, 1'b0);
    end

    repeat (4) @(posedge hram_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
